// File: rtl/uart_rx.sv
// UART receiver: oversamples an idle-high serial line, assembles WIDTH-bit frames
// and hands good bytes to a downstream FIFO, flagging framing errors and overruns.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned WIDTH        = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rx,
    input  logic             i_full,
    output logic             o_wr_en,
    output logic [WIDTH-1:0] o_wr_data,
    output logic             o_frame_err,
    output logic             o_overrun,
    output logic             o_busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic               rx_meta;
    logic               rx_s;

    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [WIDTH-1:0]   shreg_q;
    logic [WIDTH-1:0]   shreg_d;
    logic [WIDTH-1:0]   wr_data_q;
    logic [WIDTH-1:0]   wr_data_d;
    logic               wr_en_q;
    logic               wr_en_d;
    logic               ferr_q;
    logic               ferr_d;
    logic               ovr_q;
    logic               ovr_d;
    logic               busy_q;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, baud counter, bit assembly and result pulses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A start bit that is no longer low at mid-bit was a glitch.
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                        if (!i_full) begin
                            wr_en_d   = 1'b1;
                            wr_data_d = shreg_q;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Busy is registered from the next state so it tracks state_q exactly.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign o_wr_en     = wr_en_q;
    assign o_wr_data   = wr_data_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
    assign o_busy      = busy_q;

    // Result pulses are exclusive and the baud counter stays within one bit period.
    a_pulse_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0({wr_en_q, ferr_q, ovr_q}));

    a_cnt_range: assert property (@(posedge i_clk) disable iff (i_rst)
        cnt_q <= CNT_LAST);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit, 8 data bits.
module tb_uart_rx;

    localparam int unsigned CPB = 16;
    localparam int unsigned W   = 8;
    // Drive at negedge N: sync flops load at N+1/N+2, FSM reads rx_s=0 at N+3,
    // result pulse follows 7+1+144 = 152 edges later.
    localparam int LAT = 3 + 152;

    localparam int K_OK   = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    logic         clk;
    logic         rst;
    logic         rx;
    logic         full;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         frame_err;
    logic         overrun;
    logic         busy;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .WIDTH        (W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx),
        .i_full      (full),
        .o_wr_en     (wr_en),
        .o_wr_data   (wr_data),
        .o_frame_err (frame_err),
        .o_overrun   (overrun),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at a negedge right after the stop bit (or after
    // raising the line when the stop bit is held low). i_full is inverted during
    // start/data bits so only its value at the stop sample may matter.
    task automatic send_frame(input logic [7:0] d, input int kind, input int stop_low_bits);
        exp_t e;
        e.kind = kind;
        e.data = (kind == K_OK) ? d : last_good;
        e.cyc  = cyc + LAT;
        if (kind == K_OK) last_good = d;
        sb.push_back(e);

        full = (kind == K_OVR) ? 1'b0 : 1'b1;
        rx   = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        full = (kind == K_OVR);
        if (stop_low_bits > 0) begin
            rx = 1'b0;
            repeat (CPB * stop_low_bits) @(negedge clk);
            rx = 1'b1;
        end else begin
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        full = 1'b0;
    endtask

    // Monitor: every result pulse is popped against the scoreboard.
    int         m_hot;
    int         m_kind;
    exp_t       m_e;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            m_hot = int'(wr_en) + int'(frame_err) + int'(overrun);
            if (m_hot != 0) begin
                check("pulse_exclusive", 32'(m_hot), 32'd1);
                m_kind = wr_en ? K_OK : (frame_err ? K_FERR : K_OVR);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got kind %0d expected none (cycle %0d)", m_kind, cyc);
                end else begin
                    m_e = sb.pop_front();
                    check("pulse_kind", 32'(m_kind), 32'(m_e.kind));
                    check("wr_data", 32'(wr_data), 32'(m_e.data));
                    check("latency", 32'(cyc), 32'(m_e.cyc));
                end
            end
            if (wr_data !== prev_data && !wr_en) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_data_hold: got %0h expected %0h (cycle %0d)", wr_data, prev_data, cyc);
            end
        end
        prev_data = wr_data;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        rst  = 1'b1;
        rx   = 1'b1;
        full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Good frame; full toggles outside the stop sample without effect.
        send_frame(8'h41, K_OK, 0);
        repeat (20) @(negedge clk);
        check("idle_after_41", 32'(busy), 32'd0);

        // 5-cycle low glitch: START runs half a bit (8 cycles) then rejects it.
        busy_cnt = 0;
        rx = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) rx = 1'b1;
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("glitch_busy_cycles", 32'(busy_cnt), 32'd8);
        check("glitch_idle", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);

        // Stop bit low for 20 bit times: framing error, busy until line high.
        send_frame(8'h5A, K_FERR, 20);
        repeat (2) @(negedge clk);
        check("ferr_busy_held", 32'(busy), 32'd1);
        @(negedge clk);
        check("ferr_busy_release", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);

        // Overrun: byte dropped, output data keeps 0x41.
        send_frame(8'h7A, K_OVR, 0);
        repeat (20) @(negedge clk);
        check("ovr_data_kept", 32'(wr_data), 32'h41);

        // Back-to-back frames, 160 cycles apart.
        send_frame(8'h00, K_OK, 0);
        send_frame(8'hFF, K_OK, 0);
        send_frame(8'h61, K_OK, 0);
        repeat (20) @(negedge clk);

        // Reset in the middle of data bit 4 aborts the frame silently.
        rx   = 1'b0;
        full = 1'b1;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wr_data", 32'(wr_data), 32'd0);
        last_good = 8'h00;
        @(negedge clk);
        rx   = 1'b1;
        full = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("postrst_idle", 32'(busy), 32'd0);
        send_frame(8'h33, K_OK, 0);
        repeat (20) @(negedge clk);
        check("final_data", 32'(wr_data), 32'h33);

        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        while (sb.size() != 0) begin
            m_e = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_pulse: got none expected kind %0d data %0h", m_e.kind, m_e.data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
